// File: rtl/spi_transmit.sv
`timescale 1ns/1ps
// spi_transmit
// SPI slave transmitter (mode 0, MSB first). It returns processed pixel bytes
// to the MCU. Bytes are queued through a valid/ready handshake into a small
// FIFO. The MCU-driven spiClk and cs are synchronized into the clk domain and
// edge-detected, so everything runs on clk.
//
// Ports:
//   clk       system clock, all state on its rising edge
//   rst       synchronous active-high reset
//   txData    byte to transmit
//   txValid   txData is valid
//   txReady   FIFO can accept a byte
//   spiClk    SPI clock from the MCU (asynchronous)
//   cs        chip select from the MCU, active-high
//   sdo       serial data to the MCU
//   busy      synchronized cs is high
//   underrun  one-cycle pulse when a byte slot starts with the FIFO empty
module spi_transmit #(
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] txData,
   input  logic       txValid,
   output logic       txReady,
   input  logic       spiClk,
   input  logic       cs,
   output logic       sdo,
   output logic       busy,
   output logic       underrun
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   // FIFO storage
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   // Synchronizer chains: SYNC_STAGES flops plus one history flop each
   logic [SYNC_STAGES:0] sck_pipe;
   logic [SYNC_STAGES:0] cs_pipe;

   logic sck_sync;
   logic sck_hist;
   logic cs_sync;
   logic cs_hist;
   logic cs_rise;
   logic cs_fall;
   logic sck_fall;

   logic [7:0] shreg;
   logic [2:0] bit_cnt;

   logic       push;
   logic       pop;
   logic       load;
   logic       empty;
   logic [7:0] next_byte;

   assign sck_sync = sck_pipe[SYNC_STAGES-1];
   assign sck_hist = sck_pipe[SYNC_STAGES];
   assign cs_sync  = cs_pipe[SYNC_STAGES-1];
   assign cs_hist  = cs_pipe[SYNC_STAGES];

   assign cs_rise  = cs_sync && !cs_hist;
   assign cs_fall  = !cs_sync && cs_hist;
   assign sck_fall = !sck_sync && sck_hist;

   assign empty   = (count == '0);
   assign txReady = !rst && (count < FULL_COUNT);
   assign push    = txValid && txReady;

   // A new byte slot starts on cs rising or after the eighth falling spiClk.
   // cs_rise implies cs_sync, so the two terms never disagree on the load.
   assign load      = cs_rise || (sck_fall && cs_sync && (bit_cnt == 3'd7));
   // An empty FIFO is never bypassed, even if a push lands in the same cycle.
   assign pop       = load && !empty;
   assign next_byte = empty ? 8'h00 : mem[rd_ptr];

   assign sdo  = cs_sync && shreg[7];
   assign busy = cs_sync;

   // Synchronizers
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_pipe <= '0;
         cs_pipe  <= '0;
      end else begin
         sck_pipe <= {sck_pipe[SYNC_STAGES-1:0], spiClk};
         cs_pipe  <= {cs_pipe[SYNC_STAGES-1:0], cs};
      end
   end

   // FIFO data (no reset needed, validity is tracked by count)
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= txData;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Shift register, bit counter and underrun flag
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg    <= '0;
         bit_cnt  <= '0;
         underrun <= 1'b0;
      end else begin
         underrun <= load && empty;
         if (cs_rise) begin
            shreg   <= next_byte;
            bit_cnt <= '0;
         end else if (cs_fall) begin
            // Aborted byte is dropped; it was already popped and is not resent
            shreg   <= '0;
            bit_cnt <= '0;
         end else if (sck_fall && cs_sync) begin
            if (bit_cnt == 3'd7) begin
               shreg   <= next_byte;
               bit_cnt <= '0;
            end else begin
               shreg   <= {shreg[6:0], 1'b0};
               bit_cnt <= bit_cnt + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_transmit.sv
`timescale 1ns/1ps
// tb_spi_transmit
// Directed bench for spi_transmit: plays the MCU side of a mode-0 SPI link
// with spiClk = clk/16 and checks received bytes, handshake and underrun.
module tb_spi_transmit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] txData = 8'h00;
   logic       txValid = 1'b0;
   logic       txReady;
   logic       spiClk = 1'b0;
   logic       cs = 1'b0;
   logic       sdo;
   logic       busy;
   logic       underrun;

   int total = 0;
   int bad   = 0;

   // Cycle counts of underrun high and of txReady low outside reset
   int ucnt = 0;
   int rdy_low_cnt = 0;

   spi_transmit #(.DEPTH(4), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .txData   (txData),
      .txValid  (txValid),
      .txReady  (txReady),
      .spiClk   (spiClk),
      .cs       (cs),
      .sdo      (sdo),
      .busy     (busy),
      .underrun (underrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (underrun) ucnt++;
      if (!rst && !txReady) rdy_low_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      txData  = b;
      txValid = 1'b1;
      while (!txReady && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check("push_rdy", 32'(txReady), 32'd1);
      @(negedge clk);
      txValid = 1'b0;
   endtask

   task automatic cs_start();
      @(negedge clk);
      cs = 1'b1;
   endtask

   // One spiClk period; MCU samples sdo on the rising edge. On the last bit
   // of a transfer cs drops together with spiClk so no further slot starts.
   task automatic sck_bit(input logic last, output logic b);
      repeat (8) @(negedge clk);
      spiClk = 1'b1;
      b = sdo;
      repeat (8) @(negedge clk);
      spiClk = 1'b0;
      if (last) cs = 1'b0;
   endtask

   task automatic get_byte(input logic last, output logic [7:0] v);
      logic b;
      v = 8'h00;
      for (int i = 0; i < 8; i++) begin
         sck_bit(last && (i == 7), b);
         v = {v[6:0], b};
      end
   endtask

   task automatic gap();
      repeat (10) @(negedge clk);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] v, w, x;
      logic [3:0] bits;
      logic       b;
      logic       p55;
      int u0, r0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_sdo", 32'(sdo), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_under", 32'(underrun), 32'd0);
      check("rst_rdy", 32'(txReady), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_rdy", 32'(txReady), 32'd1);

      // Single byte with first-bit latency
      push(8'h9D);
      u0 = ucnt;
      r0 = rdy_low_cnt;
      cs_start();
      repeat (2) @(negedge clk);
      check("t1_lat_early", 32'(sdo), 32'd0);
      @(negedge clk);
      check("t1_lat", 32'(sdo), 32'd1);
      check("t1_busy", 32'(busy), 32'd1);
      get_byte(1'b1, v);
      gap();
      check("t1_byte", 32'(v), 32'h9D);
      check("t1_rdy_low", 32'(rdy_low_cnt - r0), 32'd0);
      check("t1_under", 32'(ucnt - u0), 32'd0);
      check("t1_busy_end", 32'(busy), 32'd0);

      // Back-to-back stream
      push(8'hFF);
      push(8'h00);
      push(8'hA5);
      u0 = ucnt;
      cs_start();
      get_byte(1'b0, v);
      get_byte(1'b0, w);
      get_byte(1'b1, x);
      gap();
      check("t2_b0", 32'(v), 32'hFF);
      check("t2_b1", 32'(w), 32'h00);
      check("t2_b2", 32'(x), 32'hA5);
      check("t2_under", 32'(ucnt - u0), 32'd0);

      // Fill and backpressure
      p55 = 1'b0;
      u0 = ucnt;
      fork
         begin
            push(8'h11);
            push(8'h22);
            push(8'h33);
            push(8'h44);
            push(8'h55);
            p55 = 1'b1;
         end
         begin
            logic [7:0] r [5];
            repeat (30) @(negedge clk);
            check("t3_full_rdy", 32'(txReady), 32'd0);
            check("t3_55_held", 32'(p55), 32'd0);
            cs_start();
            for (int i = 0; i < 5; i++) get_byte(i == 4, r[i]);
            check("t3_b0", 32'(r[0]), 32'h11);
            check("t3_b1", 32'(r[1]), 32'h22);
            check("t3_b2", 32'(r[2]), 32'h33);
            check("t3_b3", 32'(r[3]), 32'h44);
            check("t3_b4", 32'(r[4]), 32'h55);
         end
      join
      gap();
      check("t3_55_pushed", 32'(p55), 32'd1);
      check("t3_under", 32'(ucnt - u0), 32'd0);

      // Underrun, then a byte pushed mid-slot goes out in the next slot
      u0 = ucnt;
      cs_start();
      v = 8'h00;
      for (int i = 0; i < 8; i++) begin
         sck_bit(1'b0, b);
         v = {v[6:0], b};
         if (i == 2) push(8'h3C);
      end
      get_byte(1'b1, w);
      gap();
      check("t4_empty_byte", 32'(v), 32'h00);
      check("t4_next_byte", 32'(w), 32'h3C);
      check("t4_under", 32'(ucnt - u0), 32'd1);

      // Abort after three bits; aborted byte is not resent
      push(8'hC3);
      push(8'h5A);
      u0 = ucnt;
      cs_start();
      bits = 4'h0;
      for (int i = 0; i < 3; i++) begin
         sck_bit(1'b0, b);
         bits = {bits[2:0], b};
      end
      repeat (8) @(negedge clk);
      cs = 1'b0;
      gap();
      check("t5_partial", 32'(bits), 32'h6);
      cs_start();
      get_byte(1'b1, v);
      gap();
      check("t5_byte", 32'(v), 32'h5A);
      check("t5_under", 32'(ucnt - u0), 32'd0);

      // Reset mid-transfer with two bytes still queued
      push(8'hF0);
      push(8'h12);
      push(8'h34);
      u0 = ucnt;
      cs_start();
      bits = 4'h0;
      for (int i = 0; i < 4; i++) begin
         sck_bit(1'b0, b);
         bits = {bits[2:0], b};
      end
      check("t6_first_bits", 32'(bits), 32'hF);
      @(negedge clk);
      rst = 1'b1;
      cs  = 1'b0;
      @(negedge clk);
      check("t6_rst_sdo", 32'(sdo), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_rdy", 32'(txReady), 32'd0);
      @(negedge clk);
      check("t6_rst_rdy2", 32'(txReady), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("t6_post_rdy", 32'(txReady), 32'd1);
      check("t6_no_under", 32'(ucnt - u0), 32'd0);
      gap();
      u0 = ucnt;
      cs_start();
      get_byte(1'b1, v);
      gap();
      check("t6_byte", 32'(v), 32'h00);
      check("t6_under", 32'(ucnt - u0), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
